// File: rtl/milano_pkg.sv
// Shared types and constants for the milano core front end.
package milano_pkg;

    typedef enum logic {FETCH_IDLE, FETCH_RUN} fetch_state_e;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/milano_fetch_fifo.sv
// Prefetch FIFO: array storage, pointer-based, with a registered head entry
// so the consumer sees data one cycle after the push.
module milano_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    rd_ptr_next;
    logic [PW:0]      count_reg;
    logic [PW:0]      count_next;
    logic [PW:0]      remain;
    logic [WIDTH-1:0] head_reg;
    logic             do_pop;

    assign do_pop      = pop_i && (count_reg != '0);
    assign rd_ptr_next = rd_ptr_reg + PW'(do_pop);
    assign remain      = count_reg - (PW+1)'(do_pop);
    assign count_next  = remain + (PW+1)'(push_i);

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem[wr_ptr_reg] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // A push landing in a FIFO that is empty after this cycle's pop bypasses
    // the array, otherwise the new head is read from the array.
    always_ff @(posedge clk) begin
        if (srst) begin
            head_reg <= '0;
        end else if (!flush_i && count_next != '0) begin
            head_reg <= (push_i && remain == '0) ? din_i : mem[rd_ptr_next];
        end
    end

    assign head_o  = head_reg;
    assign full_o  = (count_reg == (PW+1)'(DEPTH));
    assign empty_o = (count_reg == '0);
    assign count_o = count_reg;

endmodule

// File: rtl/milano_prefetch_if.sv
// Instruction-fetch unit: credit-limited pipelined requests to instruction
// memory, in-order response buffering, and branch redirect with discard.
module milano_prefetch_if
    import milano_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] boot_addr_i,
    input  logic              fetch_en_i,
    output logic              instr_req_o,
    output logic [ADDR_W-1:0] instr_addr_o,
    input  logic              instr_gnt_i,
    input  logic              instr_rvalid_i,
    input  logic [DATA_W-1:0] instr_rdata_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              instr_valid_id_o,
    input  logic              instr_ready_id_i,
    output logic [DATA_W-1:0] instr_rdata_id_o,
    output logic [ADDR_W-1:0] instr_addr_id_o,
    output logic              busy_o
);

    localparam int                CW         = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INSTR_BYTES - 1));

    fetch_state_e      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] rsp_pc_reg, rsp_pc_next;
    logic [CW-1:0]     outstanding_reg, outstanding_next;
    logic [CW-1:0]     discard_reg, discard_next;
    logic              req_pending_reg;

    logic              req, granted, accept, drop, push, pop, credit_ok;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       in_use;
    logic [ADDR_W+DATA_W-1:0] fifo_head;

    // outstanding counts only responses that will be kept; discard_reg counts
    // the ones already condemned by a redirect, so the sum is all in flight.
    assign in_use    = {1'b0, outstanding_reg} + {1'b0, discard_reg} + {1'b0, fifo_count};
    assign credit_ok = !fifo_full && (in_use < (CW+1)'(DEPTH));
    assign req       = (state_reg == FETCH_RUN) && (req_pending_reg || (fetch_en_i && credit_ok));
    assign granted   = req && instr_gnt_i;
    assign drop      = instr_rvalid_i && (discard_reg != '0);
    assign accept    = instr_rvalid_i && (discard_reg == '0);
    assign push      = accept && !branch_i;
    assign pop       = !fifo_empty && instr_ready_id_i && !branch_i;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH_IDLE: if (fetch_en_i) state_next = FETCH_RUN;
            FETCH_RUN:  if (!fetch_en_i && !(req && !instr_gnt_i)) state_next = FETCH_IDLE;
            default:    state_next = FETCH_IDLE;
        endcase
    end

    always_comb begin
        pc_next          = pc_reg;
        rsp_pc_next      = rsp_pc_reg;
        outstanding_next = outstanding_reg + CW'(granted) - CW'(accept);
        discard_next     = discard_reg - CW'(drop);
        if (branch_i) begin
            pc_next          = branch_target_i & ALIGN_MASK;
            rsp_pc_next      = branch_target_i & ALIGN_MASK;
            discard_next     = outstanding_reg + discard_reg + CW'(granted) - CW'(instr_rvalid_i);
            outstanding_next = '0;
        end else begin
            if (granted) pc_next = pc_reg + STEP;
            if (push)    rsp_pc_next = rsp_pc_reg + STEP;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg       <= FETCH_IDLE;
            pc_reg          <= boot_addr_i & ALIGN_MASK;
            rsp_pc_reg      <= boot_addr_i & ALIGN_MASK;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            req_pending_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            rsp_pc_reg      <= rsp_pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            req_pending_reg <= req && !instr_gnt_i;
        end
    end

    milano_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk     (clk_i),
        .srst    (rst_i),
        .flush_i (branch_i),
        .push_i  (push),
        .din_i   ({rsp_pc_reg, instr_rdata_i}),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign instr_req_o      = req;
    assign instr_addr_o     = pc_reg;
    assign instr_valid_id_o = !fifo_empty;
    assign instr_addr_id_o  = fifo_head[ADDR_W+DATA_W-1:DATA_W];
    assign instr_rdata_id_o = fifo_head[DATA_W-1:0];
    assign busy_o           = (outstanding_reg != '0) || (discard_reg != '0);

endmodule

// File: tb/tb_milano_prefetch_if.sv
// Bench for milano_prefetch_if: directed scenarios plus a randomized run,
// all checked every cycle against a queue-based model of fetch behaviour.
module tb_milano_prefetch_if;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] boot_addr_i = '0;
    logic        fetch_en_i = 1'b0;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        instr_valid_id_o;
    logic        instr_ready_id_i = 1'b0;
    logic [31:0] instr_rdata_id_o;
    logic [31:0] instr_addr_id_o;
    logic        busy_o;

    milano_prefetch_if #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .boot_addr_i      (boot_addr_i),
        .fetch_en_i       (fetch_en_i),
        .instr_req_o      (instr_req_o),
        .instr_addr_o     (instr_addr_o),
        .instr_gnt_i      (instr_gnt_i),
        .instr_rvalid_i   (instr_rvalid_i),
        .instr_rdata_i    (instr_rdata_i),
        .branch_i         (branch_i),
        .branch_target_i  (branch_target_i),
        .instr_valid_id_o (instr_valid_id_o),
        .instr_ready_id_i (instr_ready_id_i),
        .instr_rdata_id_o (instr_rdata_id_o),
        .instr_addr_id_o  (instr_addr_id_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        bit          disc;
        int          gcyc;
    } fl_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } fe_t;

    // Model: fetches in flight (oldest first) and entries visible to ID.
    fl_t         inflight[$];
    fe_t         fifo_q[$];
    logic [31:0] m_pc;
    bit          m_run, m_pend, m_ok;

    int          gnt_sel, rv_sel, ready_sel;
    bit          br_req, verbose;
    logic [31:0] br_tgt;
    int          cyc, checks, errors;

    logic        s_req, s_gnt, s_valid;
    logic [31:0] s_addr, s_addr_id, s_rdata;

    function automatic logic [31:0] memdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare at the negedge, advance the model.
    task automatic step();
        fl_t ent;
        fe_t fe;
        bit  exp_req, granted, popped, new_run;
        instr_gnt_i = (gnt_sel == 1) || (gnt_sel == 2 && $urandom_range(0, 2) != 0);
        if (!rst_i && inflight.size() != 0 && inflight[0].gcyc < cyc &&
            (rv_sel == 1 || (rv_sel == 2 && $urandom_range(0, 2) != 0))) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = memdata(inflight[0].addr);
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = $urandom;
        end
        instr_ready_id_i = (ready_sel == 1) || (ready_sel == 2 && $urandom_range(0, 3) != 0);
        branch_i        = br_req && !rst_i;
        branch_target_i = br_tgt;
        br_req          = 1'b0;

        @(negedge clk_i);
        s_req = instr_req_o;  s_gnt = instr_gnt_i;  s_addr = instr_addr_o;
        s_valid = instr_valid_id_o;  s_addr_id = instr_addr_id_o;  s_rdata = instr_rdata_id_o;

        exp_req = m_run && (m_pend || (fetch_en_i && (inflight.size() + fifo_q.size() < DEPTH)));
        if (m_ok) begin
            chk("req", instr_req_o, exp_req);
            chk("addr", instr_addr_o, m_pc);
            chk("valid_id", instr_valid_id_o, fifo_q.size() != 0);
            if (fifo_q.size() != 0) begin
                chk("addr_id", instr_addr_id_o, fifo_q[0].addr);
                chk("rdata_id", instr_rdata_id_o, fifo_q[0].data);
            end
            chk("busy", busy_o, inflight.size() != 0);
        end

        if (rst_i) begin
            inflight.delete();
            fifo_q.delete();
            m_pc   = boot_addr_i & 32'hFFFF_FFFC;
            m_run  = 1'b0;
            m_pend = 1'b0;
            m_ok   = 1'b1;
        end else begin
            granted = exp_req && instr_gnt_i;
            popped  = (fifo_q.size() != 0) && instr_ready_id_i && !branch_i;
            if (popped) begin
                fe = fifo_q.pop_front();
                if (verbose) $display("txn cycle %0d: addr=%h data=%h", cyc, fe.addr, fe.data);
            end
            if (instr_rvalid_i) begin
                ent = inflight.pop_front();
                if (!ent.disc && !branch_i) begin
                    fe.addr = ent.addr;
                    fe.data = instr_rdata_i;
                    fifo_q.push_back(fe);
                end
            end
            if (granted) begin
                ent.addr = m_pc;
                ent.disc = 1'b0;
                ent.gcyc = cyc;
                inflight.push_back(ent);
            end
            if (branch_i) begin
                fifo_q.delete();
                foreach (inflight[i]) inflight[i].disc = 1'b1;
                m_pc = branch_target_i & 32'hFFFF_FFFC;
            end else if (granted) begin
                m_pc = m_pc + 32'd4;
            end
            new_run = m_run ? !(!fetch_en_i && !(exp_req && !instr_gnt_i)) : fetch_en_i;
            m_pend  = exp_req && !instr_gnt_i;
            m_run   = new_run;
        end

        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic [31:0] boot);
        rst_i       = 1'b1;
        boot_addr_i = boot;
        br_req      = 1'b0;
        repeat (2) step();
        chk("rst_req", instr_req_o, 0);
        chk("rst_valid", instr_valid_id_o, 0);
        chk("rst_rdata_id", instr_rdata_id_o, 0);
        chk("rst_addr_id", instr_addr_id_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_addr", instr_addr_o, boot & 32'hFFFF_FFFC);
        rst_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          first, nvalid, ng, n;
        bit          found;
        logic [31:0] got [3];
        cyc = 0; checks = 0; errors = 0; m_ok = 0; verbose = 1;
        br_req = 0; br_tgt = '0;
        @(posedge clk_i);
        #1;

        // Boot stream with zero-wait memory and ID always ready.
        fetch_en_i = 1; gnt_sel = 1; rv_sel = 1; ready_sel = 1;
        do_reset(32'h8000_0002);
        first = -1; nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) chk("boot_idle_req", s_req, 0);
            if (i == 1) begin
                chk("boot_first_req", s_req, 1);
                chk("boot_first_addr", s_addr, 32'h8000_0000);
            end
            if (s_valid && first < 0) first = i;
            if (i >= 3) begin
                if (s_valid) nvalid++;
                chk("boot_stream_addr", s_addr_id, 32'h8000_0000 + 32'(4 * (i - 3)));
            end
        end
        chk("boot_first_valid_cycle", first, 3);
        chk("boot_throughput", nvalid, 7);

        // Back-pressure: ID stalled, credit caps fetches at DEPTH.
        ready_sel = 0;
        do_reset(32'h0000_1000);
        ng = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (s_req && s_gnt) ng++;
        end
        chk("bp_grants", ng, 4);
        chk("bp_req_low", s_req, 0);
        ready_sel = 1;
        step();
        ready_sel = 0;
        ng = (s_req && s_gnt) ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (s_req && s_gnt) ng++;
        end
        chk("bp_one_more_grant", ng, 1);

        // Branch with two fetches outstanding.
        ready_sel = 1; gnt_sel = 1; rv_sel = 0;
        do_reset(32'h0000_0040);
        repeat (3) step();
        gnt_sel = 0; br_req = 1; br_tgt = 32'h0000_0103;
        step();
        gnt_sel = 1; rv_sel = 1; found = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (s_valid && !found) begin
                found = 1;
                chk("br_first_addr", s_addr_id, 32'h0000_0100);
                chk("br_first_data", s_rdata, memdata(32'h0000_0100));
            end
        end
        chk("br_delivered", found, 1);

        // Branch coinciding with a grant and a response.
        gnt_sel = 1; rv_sel = 0;
        do_reset(32'h0000_0080);
        repeat (3) step();
        rv_sel = 1; br_req = 1; br_tgt = 32'h0000_0200;
        step();
        chk("brsim_rvalid_in_branch", instr_rvalid_i, 1);
        found = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (s_valid && !found) begin
                found = 1;
                chk("brsim_first_addr", s_addr_id, 32'h0000_0200);
            end
        end
        chk("brsim_delivered", found, 1);

        // Address wrap-around at the top of the address space.
        do_reset(32'hFFFF_FFF8);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_valid && n < 3) begin
                got[n] = s_addr_id;
                n++;
            end
        end
        chk("wrap_0", got[0], 32'hFFFF_FFF8);
        chk("wrap_1", got[1], 32'hFFFF_FFFC);
        chk("wrap_2", got[2], 32'h0000_0000);

        // Stalled grant: request held stable, survives fetch_en dropping.
        gnt_sel = 0; fetch_en_i = 1;
        do_reset(32'h0000_2000);
        repeat (2) step();
        chk("stall_req_up", s_req, 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) fetch_en_i = 0;
            step();
            chk("stall_req_held", s_req, 1);
            chk("stall_addr_held", s_addr, 32'h0000_2000);
        end
        gnt_sel = 1;
        step();
        chk("stall_granted_req", s_req, 1);
        step();
        chk("stall_req_dropped", s_req, 0);
        step();
        chk("stall_req_stays_low", s_req, 0);

        // Randomized traffic with redirects, enable toggling and resets.
        verbose = 0; fetch_en_i = 1; gnt_sel = 2; rv_sel = 2; ready_sel = 2;
        do_reset($urandom);
        for (int i = 0; i < 3000; i++) begin
            if (fetch_en_i ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 4) == 0))
                fetch_en_i = !fetch_en_i;
            if ($urandom_range(0, 15) == 0) begin
                br_req = 1;
                br_tgt = $urandom;
            end
            ready_sel = ($urandom_range(0, 7) == 0) ? 0 : 2;
            if ($urandom_range(0, 999) == 0)
                do_reset(($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom);
            else
                step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
